// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader slice: default widths, default
// read latency and the loader FSM state encoding.
package boot_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_RD_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WR    = 3'd2,
        ST_RD    = 3'd3,
        ST_RDW   = 3'd4,
        ST_RUN   = 3'd5,
        ST_ERROR = 3'd6
    } state_t;
endpackage

// File: rtl/boot_loader_if.sv
// Stream + RAM port bundle of the boot loader.
//   in_valid/in_data/in_ready : word stream into the loader
//   ram_addr/ram_wdata/ram_read/ram_write : RAM request (loader or CU)
//   ram_rdata : RAM read data
// master = the loader side, slave = stream source and RAM.
interface boot_loader_if
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_read;
    logic                  ram_write;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        input  in_valid, in_data, ram_rdata,
        output in_ready, ram_addr, ram_wdata, ram_read, ram_write
    );

    modport slave (
        output in_valid, in_data, ram_rdata,
        input  in_ready, ram_addr, ram_wdata, ram_read, ram_write
    );
endinterface

// File: rtl/ram_port_mux.sv
// RAM port arbiter: hands the port to the CU when sel (cu_enable) is high,
// otherwise presents the loader's registered request.
//   sel        : 1 = CU owns the port
//   ld_*       : loader request
//   cu_*       : CU request
//   ram_*      : resolved RAM request
module ram_port_mux
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  sel,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    input  logic                  ld_read,
    input  logic                  ld_write,
    input  logic [ADDR_WIDTH-1:0] cu_addr,
    input  logic [DATA_WIDTH-1:0] cu_wdata,
    input  logic                  cu_read,
    input  logic                  cu_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_read,
    output logic                  ram_write
);
    assign ram_addr  = sel ? cu_addr  : ld_addr;
    assign ram_wdata = sel ? cu_wdata : ld_wdata;
    assign ram_read  = sel ? cu_read  : ld_read;
    assign ram_write = sel ? cu_write : ld_write;
endmodule

// File: rtl/boot_loader.sv
// Program/data preloader between the CU and RAM. While the CU is held off it
// takes words from a valid/ready stream, writes them to consecutive RAM
// addresses from base_addr and optionally reads each back to verify. On
// success it enters RUN (cu_enable=1, CU owns RAM); on mismatch it latches
// error/err_addr and parks in ERROR.
//   clk, reset        : clock, synchronous active-high reset
//   start             : load request (accepted in IDLE/RUN/ERROR only)
//   base_addr, word_count, verify : load parameters, sampled on start
//   cu_*              : CU RAM request, passed through in RUN only
//   cu_rdata          : RAM read data to the CU
//   cu_enable, busy   : status
//   error, err_addr   : verify mismatch flag and first failing address
//   bus               : stream and RAM port
module boot_loader
    import boot_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  verify,
    input  logic [ADDR_WIDTH-1:0] cu_addr,
    input  logic [DATA_WIDTH-1:0] cu_wdata,
    input  logic                  cu_read,
    input  logic                  cu_write,
    output logic [DATA_WIDTH-1:0] cu_rdata,
    output logic                  cu_enable,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_addr,
    boot_loader_if.master         bus
);
    localparam int LW = $clog2(RD_LATENCY + 1);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   rem;
    logic                  verify_q;
    logic [LW-1:0]         lat_cnt;
    logic                  in_ready_q, busy_q, cu_en_q, error_q;
    logic                  ld_read, ld_write;
    logic [ADDR_WIDTH-1:0] ld_addr, err_addr_q;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic [ADDR_WIDTH-1:0] mux_addr;
    logic [DATA_WIDTH-1:0] mux_wdata;
    logic                  mux_read, mux_write;

    logic start_ok, accept, rd_done, match, last, advance;

    assign start_ok = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);
    assign accept   = bus.in_valid && in_ready_q;
    // lat_cnt counts cycles elapsed since the RD cycle; the compare happens
    // when exactly RD_LATENCY have passed.
    assign rd_done  = (state == ST_RDW) && (lat_cnt == LW'(RD_LATENCY));
    // ld_wdata still holds the word just written, so it doubles as the
    // reference for the read-back compare.
    assign match    = (bus.ram_rdata == ld_wdata);
    assign last     = (rem == (ADDR_WIDTH+1)'(1));
    assign advance  = (state == ST_WR && !verify_q) || (rd_done && match);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_RUN, ST_ERROR:
                if (start_ok) state_n = (word_count == '0) ? ST_RUN : ST_LOAD;
            ST_LOAD:
                if (accept) state_n = ST_WR;
            ST_WR:
                if (verify_q) state_n = ST_RD;
                else          state_n = last ? ST_RUN : ST_LOAD;
            ST_RD:
                state_n = ST_RDW;
            ST_RDW:
                if (rd_done) begin
                    if (!match)    state_n = ST_ERROR;
                    else if (last) state_n = ST_RUN;
                    else           state_n = ST_LOAD;
                end
            default:
                state_n = ST_IDLE;
        endcase
    end

    // All loader-side outputs are flops decoded from the next state so they
    // line up with the state register without a combinational decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            cu_en_q    <= 1'b0;
            ld_write   <= 1'b0;
            ld_read    <= 1'b0;
            ld_addr    <= '0;
            ld_wdata   <= '0;
            ptr        <= '0;
            rem        <= '0;
            verify_q   <= 1'b0;
            lat_cnt    <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            in_ready_q <= (state_n == ST_LOAD);
            busy_q     <= (state_n == ST_LOAD) || (state_n == ST_WR) ||
                          (state_n == ST_RD)   || (state_n == ST_RDW);
            cu_en_q    <= (state_n == ST_RUN);
            ld_write   <= (state_n == ST_WR);
            ld_read    <= (state_n == ST_RD);

            if (start_ok) begin
                ptr        <= base_addr;
                rem        <= word_count;
                verify_q   <= verify;
                error_q    <= 1'b0;
                err_addr_q <= '0;
            end

            if (accept) begin
                ld_addr  <= ptr;
                ld_wdata <= bus.in_data;
            end

            // Pointer wraps naturally at 2^ADDR_WIDTH.
            if (advance) begin
                ptr <= ptr + 1'b1;
                rem <= rem - 1'b1;
            end

            if (state == ST_RD)
                lat_cnt <= LW'(1);
            else if (state == ST_RDW && !rd_done)
                lat_cnt <= lat_cnt + 1'b1;

            if (rd_done && !match) begin
                error_q    <= 1'b1;
                err_addr_q <= ptr;
            end
        end
    end

    ram_port_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mux (
        .sel       (cu_en_q),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_read   (ld_read),
        .ld_write  (ld_write),
        .cu_addr   (cu_addr),
        .cu_wdata  (cu_wdata),
        .cu_read   (cu_read),
        .cu_write  (cu_write),
        .ram_addr  (mux_addr),
        .ram_wdata (mux_wdata),
        .ram_read  (mux_read),
        .ram_write (mux_write)
    );

    assign bus.ram_addr  = mux_addr;
    assign bus.ram_wdata = mux_wdata;
    assign bus.ram_read  = mux_read;
    assign bus.ram_write = mux_write;
    assign bus.in_ready  = in_ready_q;

    assign cu_rdata  = bus.ram_rdata;
    assign cu_enable = cu_en_q;
    assign busy      = busy_q;
    assign error     = error_q;
    assign err_addr  = err_addr_q;
endmodule
